wvb_rd_seq: RTL and testbench

Parametrised waveform-buffer read sequencer that replaces the fixed-latency, single-mode read address controller. It pops one event header from the header FIFO, then streams every sample address from start to stop with wrap-around at the buffer depth, under consumer backpressure. It emits valid/last flags aligned to the waveform RAM read latency, publishes a freed-space pointer for the write-side overflow logic, and supports event abort. It sits between the header FIFO / waveform RAM and the readout formatter.

---
 rtl/wvb_rd_pkg.sv | 24 ++
 rtl/wvb_rd_dly_line.sv | 32 +++
 rtl/wvb_rd_seq.sv | 105 ++++++++++
 tb/tb_wvb_rd_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_rd_pkg.sv
// Shared definitions for the waveform-buffer read sequencer: FSM encoding
// and the event-length helper.
package wvb_rd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HDR_REQ  = 3'd1,
    HDR_WAIT = 3'd2,
    STREAM   = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  // Sample count from start to stop inclusive, modulo 2^width; range 1..2^width.
  function automatic logic [32:0] wvb_len(input logic [31:0] start,
                                          input logic [31:0] stop,
                                          input int unsigned width);
    logic [32:0] mask;
    logic [32:0] diff;
    mask = (33'd1 << width) - 33'd1;
    diff = ({1'b0, stop} - {1'b0, start}) & mask;
    return diff + 33'd1;
  endfunction

endpackage

// File: rtl/wvb_rd_dly_line.sv
// Fixed-latency shift register with synchronous clear; LAT = 0 is a
// pass-through that is still forced low while clear is asserted.
module wvb_rd_dly_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (LAT == 0) begin : g_pass
      assign q = clr ? '0 : d;
    end else begin : g_pipe
      logic [WIDTH-1:0] sr [LAT];

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int unsigned i = 0; i < LAT; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int unsigned i = 1; i < LAT; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[LAT-1];
    end
  endgenerate

endmodule

// File: rtl/wvb_rd_seq.sv
// Waveform-buffer read sequencer: pops one header, streams start..stop with
// wrap-around under backpressure, and retires the event after the RAM latency.
module wvb_rd_seq
  import wvb_rd_pkg::*;
#(
  parameter int unsigned P_ADR_WIDTH = 12,
  parameter int unsigned P_HDR_LAT   = 2,
  parameter int unsigned P_RAM_LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hdr_empty,
  output logic                   hdr_rdreq,
  input  logic [P_ADR_WIDTH-1:0] hdr_start_addr,
  input  logic [P_ADR_WIDTH-1:0] hdr_stop_addr,
  input  logic                   rd_en,
  input  logic                   abort,
  output logic [P_ADR_WIDTH-1:0] wvb_rd_addr,
  output logic                   rd_valid,
  output logic                   rd_last,
  output logic [P_ADR_WIDTH:0]   evt_len,
  output logic                   evt_done,
  output logic [P_ADR_WIDTH-1:0] rd_ptr,
  output logic                   busy
);

  localparam int unsigned LW = P_ADR_WIDTH + 1;

  state_t                 state, state_n;
  logic [2:0]             cnt;
  logic [P_ADR_WIDTH-1:0] addr;
  logic [P_ADR_WIDTH-1:0] stop_q;
  logic [LW-1:0]          remaining;
  logic [LW-1:0]          len_hdr;
  logic                   hdr_vld;
  logic                   issue;
  logic                   issue_last;
  logic                   flush_end;

  assign len_hdr = LW'(wvb_len(32'(hdr_start_addr), 32'(hdr_stop_addr), P_ADR_WIDTH));

  // An abort only suppresses the issue when it is not the final one.
  always_comb begin
    hdr_vld    = (state == HDR_WAIT) && (cnt == 3'(P_HDR_LAT - 1));
    issue      = (state == STREAM) && rd_en && (!abort || (remaining == LW'(1)));
    issue_last = issue && (remaining == LW'(1));
    flush_end  = (state == FLUSH) && (cnt == 3'(P_RAM_LAT));
    state_n    = state;
    case (state)
      IDLE:     if (!hdr_empty) state_n = HDR_REQ;
      HDR_REQ:  state_n = HDR_WAIT;
      HDR_WAIT: if (hdr_vld) state_n = STREAM;
      STREAM:   if (issue_last || (abort && !issue)) state_n = FLUSH;
      FLUSH:    if (flush_end) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // cnt is shared: header-latency count in HDR_WAIT, drain count in FLUSH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '1;
      stop_q    <= '0;
      remaining <= '0;
      evt_len   <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else if ((state == HDR_WAIT) || (state == FLUSH))
        cnt <= cnt + 3'd1;
      if (hdr_vld) begin
        addr      <= hdr_start_addr;
        stop_q    <= hdr_stop_addr;
        remaining <= len_hdr;
        evt_len   <= len_hdr;
      end
      if (issue) begin
        addr      <= addr + P_ADR_WIDTH'(1);
        remaining <= remaining - LW'(1);
      end
      if (flush_end)
        rd_ptr <= stop_q + P_ADR_WIDTH'(1);
    end
  end

  wvb_rd_dly_line #(
    .WIDTH (2),
    .LAT   (P_RAM_LAT)
  ) u_dly (
    .clk (clk),
    .clr (rst),
    .d   ({issue, issue_last}),
    .q   ({rd_valid, rd_last})
  );

  assign hdr_rdreq   = (state == HDR_REQ);
  assign busy        = (state != IDLE);
  assign evt_done    = flush_end;
  assign wvb_rd_addr = addr;

endmodule

// File: tb/tb_wvb_rd_seq.sv
// Bench for wvb_rd_seq: header FIFO model, RAM-latency scoreboard, table of
// full-rate events plus hand-written backpressure/abort/reset sequences.
module tb_wvb_rd_seq;

  localparam int unsigned AW = 12;
  localparam int unsigned HL = 2;
  localparam int unsigned RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          hdr_empty = 1'b1;
  logic          hdr_rdreq;
  logic [AW-1:0] hdr_start_addr;
  logic [AW-1:0] hdr_stop_addr;
  logic          rd_en;
  logic          abort;
  logic [AW-1:0] wvb_rd_addr;
  logic          rd_valid;
  logic          rd_last;
  logic [AW:0]   evt_len;
  logic          evt_done;
  logic [AW-1:0] rd_ptr;
  logic          busy;

  wvb_rd_seq #(
    .P_ADR_WIDTH (AW),
    .P_HDR_LAT   (HL),
    .P_RAM_LAT   (RL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .hdr_empty      (hdr_empty),
    .hdr_rdreq      (hdr_rdreq),
    .hdr_start_addr (hdr_start_addr),
    .hdr_stop_addr  (hdr_stop_addr),
    .rd_en          (rd_en),
    .abort          (abort),
    .wvb_rd_addr    (wvb_rd_addr),
    .rd_valid       (rd_valid),
    .rd_last        (rd_last),
    .evt_len        (evt_len),
    .evt_done       (evt_done),
    .rd_ptr         (rd_ptr),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic          l;
  } exp_t;

  typedef struct {
    int unsigned start;
    int unsigned stop;
    int unsigned len;
    int unsigned ptr;
  } vec_t;

  exp_t        exp_q[$];
  logic [23:0] fifo_q[$];
  exp_t        sb_e;
  logic [AW-1:0] hist [0:RL];
  logic [AW-1:0] pend_start, pend_stop;
  bit          pend = 1'b0;
  int unsigned pend_cnt = 0;

  int unsigned cyc = 0, valids = 0, lasts = 0, dones = 0, pops = 0;
  int unsigned pop_cyc = 0, prev_pop_cyc = 0, done_cyc = 0;
  int unsigned sb_err = 0, sb_chk = 0;

  int unsigned nerr = 0, nchk = 0;
  int unsigned base_valids, base_lasts, base_dones, base_pops;

  // Monitor: RAM data is modelled as the address seen RL cycles earlier.
  always @(negedge clk) begin
    cyc++;
    for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = wvb_rd_addr;
    if (rd_last && !rd_valid) begin
      sb_err++;
      $display("FAIL last_without_valid: rd_last=1 rd_valid=0 at cycle %0d, required rd_last=0", cyc);
    end
    if (rd_valid) begin
      valids++;
      if (rd_last) lasts++;
      sb_chk++;
      if (exp_q.size() == 0) begin
        sb_err++;
        $display("FAIL unexpected_valid: addr=0x%0h at cycle %0d, required no valid", hist[RL], cyc);
      end else begin
        sb_e = exp_q.pop_front();
        if (hist[RL] !== sb_e.a || rd_last !== sb_e.l) begin
          sb_err++;
          $display("FAIL sb_data: addr=0x%0h last=%0b, required addr=0x%0h last=%0b",
                   hist[RL], rd_last, sb_e.a, sb_e.l);
        end
      end
    end
    if (evt_done) begin
      dones++;
      done_cyc = cyc;
    end
    // Header FIFO: fields valid only in the cycle HL after the pop.
    hdr_start_addr = AW'($urandom);
    hdr_stop_addr  = AW'($urandom);
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        hdr_start_addr = pend_start;
        hdr_stop_addr  = pend_stop;
        pend = 1'b0;
      end
    end
    if (hdr_rdreq) begin
      pops++;
      prev_pop_cyc = pop_cyc;
      pop_cyc = cyc;
      if (fifo_q.size() == 0) begin
        sb_err++;
        $display("FAIL pop_empty: hdr_rdreq=1 with empty FIFO at cycle %0d, required 0", cyc);
      end else begin
        {pend_start, pend_stop} = fifo_q.pop_front();
        pend = 1'b1;
        pend_cnt = HL;
      end
    end
    hdr_empty = (fifo_q.size() == 0);
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int unsigned act, input int unsigned expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic start_evt(input int unsigned s, input int unsigned e,
                           input int unsigned n, input bit last_ok);
    exp_t x;
    base_valids = valids;
    base_lasts  = lasts;
    base_dones  = dones;
    base_pops   = pops;
    for (int unsigned i = 0; i < n; i++) begin
      x.a = AW'(s + i);
      x.l = last_ok && (i == n - 1);
      exp_q.push_back(x);
    end
    fifo_q.push_back({AW'(s), AW'(e)});
  endtask

  // Returns positioned in the first STREAM cycle.
  task automatic wait_stream(input int unsigned s);
    int unsigned t = 0;
    while (pops == base_pops && t < 1000) begin
      tick(1);
      t++;
    end
    check("pop_seen", pops - base_pops, 1);
    tick(HL + 1);
    check("first_addr", wvb_rd_addr, s);
  endtask

  task automatic finish_evt(input int unsigned len, input int unsigned ptr,
                            input int unsigned nval, input int unsigned nlast,
                            input bit timing);
    int unsigned t = 0;
    while (dones == base_dones && t < 20000) begin
      tick(1);
      t++;
    end
    tick(2);
    check("evt_done_count", dones - base_dones, 1);
    check("evt_len", evt_len, len);
    check("valid_count", valids - base_valids, nval);
    check("last_count", lasts - base_lasts, nlast);
    check("rd_ptr", rd_ptr, ptr);
    check("sb_drained", exp_q.size(), 0);
    if (timing) check("done_latency", done_cyc - pop_cyc, HL + len + RL + 1);
  endtask

  initial begin
    vec_t vecs[5];
    int   bp[7];
    logic [AW-1:0] a;
    int unsigned v0, d0, t;

    vecs[0] = '{start: 'h010, stop: 'h013, len: 4,    ptr: 'h014};
    vecs[1] = '{start: 'hFFE, stop: 'h001, len: 4,    ptr: 'h002};
    vecs[2] = '{start: 'h100, stop: 'h0FF, len: 4096, ptr: 'h100};
    vecs[3] = '{start: 'h7A0, stop: 'h7A0, len: 1,    ptr: 'h7A1};
    vecs[4] = '{start: 'hFFF, stop: 'hFFF, len: 1,    ptr: 'h000};
    bp = '{1, 0, 0, 1, 0, 1, 1};

    rst = 1'b1;
    rd_en = 1'b1;
    abort = 1'b0;
    tick(3);
    check("rst_addr", wvb_rd_addr, 'hFFF);
    check("rst_ptr", rd_ptr, 0);
    check("rst_len", evt_len, 0);
    check("rst_flags", {hdr_rdreq, rd_valid, rd_last, evt_done, busy}, 0);
    rst = 1'b0;
    tick(2);
    check("idle_busy", busy, 0);

    foreach (vecs[i]) begin
      start_evt(vecs[i].start, vecs[i].stop, vecs[i].len, 1'b1);
      wait_stream(vecs[i].start);
      finish_evt(vecs[i].len, vecs[i].ptr, vecs[i].len, 1, 1'b1);
    end

    // Backpressure on an 8-sample event.
    start_evt('h400, 'h407, 8, 1'b1);
    wait_stream('h400);
    foreach (bp[i]) begin
      rd_en = bp[i][0];
      a = wvb_rd_addr;
      tick(1);
      check("bp_addr", wvb_rd_addr, AW'(a + AW'(bp[i])));
    end
    rd_en = 1'b1;
    finish_evt(8, 'h408, 8, 1, 1'b0);

    // Abort after 3 issues of a 10-sample event.
    start_evt('h200, 'h209, 3, 1'b0);
    wait_stream('h200);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    finish_evt(10, 'h20A, 3, 0, 1'b0);

    // Abort coincident with the last issue completes normally.
    start_evt('h300, 'h302, 3, 1'b1);
    wait_stream('h300);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    finish_evt(3, 'h303, 3, 1, 1'b1);

    // Reset in the middle of a 64-sample event.
    start_evt('h600, 'h63F, 64, 1'b1);
    wait_stream('h600);
    tick(5);
    rst = 1'b1;
    tick(1);
    exp_q.delete();
    v0 = valids;
    d0 = dones;
    check("midrst_addr", wvb_rd_addr, 'hFFF);
    check("midrst_ptr", rd_ptr, 0);
    check("midrst_busy", busy, 0);
    start_evt('h640, 'h643, 4, 1'b1);
    tick(2);
    check("midrst_valids", valids - v0, 0);
    check("midrst_done", dones - d0, 0);
    rst = 1'b0;
    finish_evt(4, 'h644, 4, 1, 1'b1);

    // Back-to-back headers.
    start_evt('h700, 'h703, 4, 1'b1);
    start_evt('h704, 'h705, 2, 1'b1);
    t = 0;
    while (pops - base_pops < 2 && t < 1000) begin
      tick(1);
      t++;
    end
    check("b2b_pops", pops - base_pops, 2);
    check("b2b_gap", pop_cyc - prev_pop_cyc, HL + 4 + RL + 3);
    base_valids = valids;
    base_lasts  = lasts;
    base_dones  = dones;
    finish_evt(2, 'h706, 2, 1, 1'b1);
    tick(2);
    check("end_busy", busy, 0);

    check("scoreboard_errors", sb_err, 0);
    check("scoreboard_active", sb_chk > 4000, 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
